clk_wiz_gen: RTL and testbench
==============================

Name: clk_wiz_gen

Overview:
- Synthesizable stand-in for the vendor clocking wizard. Derives two integer-divided clocks from one fast reference clock and reports lock.
- In the sensor-control top level it sits between the board oscillator path and all downstream logic:
  - clk_out1 (100 MHz) drives the 1 MHz sensor-clock divider.
  - clk_out2 (125 MHz) is a spare output.
- Default reference is 500 MHz: clk_out1 = /5, clk_out2 = /4.

Parameters:
- DIV1, 5, clk_out1 divide ratio; integer, 2..256.
- DIV2, 4, clk_out2 divide ratio; integer, 2..256.
- PHASE1, 0, initial counter value of the clk_out1 divider at lock; 0..DIV1-1.
- PHASE2, 0, initial counter value of the clk_out2 divider at lock; 0..DIV2-1.
- LOCK_CYCLES, 64, clk_in1 rising edges after reset release before locked asserts; 1..65535.

Ports:
- clk_in1  input  1  reference clock; the only clock in the block.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- clk_out1  output  1  divided clock 1, registered.
- clk_out2  output  1  divided clock 2, registered.
- locked  output  1  high once the outputs are running.

Behaviour:
- All state is clocked on the rising edge of clk_in1.
- Reset:
  - reset=0 immediately clears the lock counter (16 bit) and locked.
  - It clears clk_out1 and clk_out2 to 0.
  - It loads the divider counters (8 bit each) with PHASE1 and PHASE2.
  - Release is used as-is, with no internal synchronizer. The integrator must meet recovery timing.
- Lock sequence:
  - After release, the lock counter increments on each edge.
  - locked goes 1 on the LOCK_CYCLES-th rising edge after release.
  - It then stays 1; the counter saturates.
- While locked=0:
  - Divider counters hold their PHASE value.
  - Outputs hold 0.
- Divider n (identical for 1 and 2), on each edge with locked=1:
  - clk_outn <= (cntn < HIGHn), where HIGHn = floor(DIVn/2).
  - cntn <= (cntn == DIVn-1) ? 0 : cntn+1.
- Divider properties:
  - Period is exactly DIVn clk_in1 cycles.
  - The high time is HIGHn cycles, so odd ratios give a sub-50% duty. With DIV=5: 2 high, 3 low.
  - With PHASEn=0, the first high output appears on the first edge after locked rises.
  - Both dividers start on the same edge, so their relative phase is deterministic.
  - No glitches: outputs come directly from flops.
- Reset mid-operation: outputs drop to 0 asynchronously, and the full LOCK_CYCLES relock repeats.
- Illegal parameters (DIV < 2, PHASE >= DIV, LOCK_CYCLES = 0) are rejected at elaboration by an assertion.

Decomposition:
- Shared package clk_wiz_pkg holds:
  - CNT_W = 8 and LOCK_W = 16.
  - Default ratio constants DIV_100M = 5 and DIV_125M = 4, assuming a 500 MHz reference.
- One natural sub-module, clk_div_n, parameterised by DIV and PHASE:
  - Inputs: clk, reset, en (= locked).
  - Output: clk_o.
  - Instantiated twice.
- The lock counter stays in the top level.

Test Plan:
- Power-up: hold reset=0 for 10 cycles -> locked=0, clk_out1=0, clk_out2=0 throughout. Release -> locked=1 exactly on edge 64 after release, outputs 0 before that.
- Default ratios: after lock, run 200 clk_in1 cycles -> clk_out1 has period 5 (2 high/3 low), clk_out2 has period 4 (2 high/2 low). The first high on each output is the edge after locked rises.
- Phase: PHASE1=3, DIV1=5 -> after lock, clk_out1 shows low, low, high, high, low, low, low, high, high...
- Mid-run reset: assert reset=0 asynchronously between edges while clk_out1=1 -> all outputs 0 and locked=0 without a clock edge. Release -> relock takes a full 64 edges.
- Ratio extremes: DIV1=2, DIV2=256, LOCK_CYCLES=1 -> locked on the first edge after release; clk_out1 toggles every cycle; clk_out2 is 128 high/128 low.
- Phase alignment: DIV1=4, DIV2=4 -> clk_out1 equals clk_out2 every cycle after lock.

Source files
------------

// File: rtl/clk_wiz_pkg.sv
// ============================================================================
// Module   : clk_wiz_pkg
// Brief    : Shared widths, default ratios and helpers for clk_wiz_gen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_wiz_pkg;

    localparam int CNT_W    = 8;
    localparam int LOCK_W   = 16;

    // Ratios assume a 500 MHz reference clock.
    localparam int DIV_100M = 5;
    localparam int DIV_125M = 4;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [LOCK_W-1:0] lock_cnt_t;

    // Odd ratios round the high time down, giving a sub-50% duty cycle.
    function automatic int high_time(input int div);
        return div / 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_wiz_gen_div.sv
// ============================================================================
// Module   : clk_div_n
// Brief    : Registered integer clock divider with a preset start phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_n
    import clk_wiz_pkg::*;
#(
    parameter int DIV   = DIV_100M,
    parameter int PHASE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic clk_o
);

    localparam cnt_t c_last  = cnt_t'(DIV - 1);
    localparam cnt_t c_high  = cnt_t'(high_time(DIV));
    localparam cnt_t c_phase = cnt_t'(PHASE);

    generate
        if (DIV < 2 || DIV > 256 || PHASE < 0 || PHASE >= DIV) begin : g_bad_param
            $error("clk_div_n: illegal DIV/PHASE combination");
        end
    endgenerate

    cnt_t r_cnt;
    logic r_clk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= c_phase;
            r_clk <= 1'b0;
        end else if (en) begin
            r_clk <= (r_cnt < c_high);
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        end else begin
            r_cnt <= c_phase;
            r_clk <= 1'b0;
        end
    end

    assign clk_o = r_clk;

endmodule

`default_nettype wire

// File: rtl/clk_wiz_gen.sv
// ============================================================================
// Module   : clk_wiz_gen
// Brief    : Clocking-wizard stand-in: two divided clocks plus a lock flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_wiz_gen
    import clk_wiz_pkg::*;
#(
    parameter int DIV1        = DIV_100M,
    parameter int DIV2        = DIV_125M,
    parameter int PHASE1      = 0,
    parameter int PHASE2      = 0,
    parameter int LOCK_CYCLES = 64
) (
    input  logic clk_in1,
    input  logic reset,
    output logic clk_out1,
    output logic clk_out2,
    output logic locked
);

    localparam lock_cnt_t c_lock_last = lock_cnt_t'(LOCK_CYCLES - 1);

    generate
        if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
            $error("clk_wiz_gen: LOCK_CYCLES out of range");
        end
    endgenerate

    lock_cnt_t r_lock_cnt;
    logic      r_locked;

    // Reset release is used unsynchronised; recovery timing is the integrator's job.
    // The counter stops once locked, so it saturates at LOCK_CYCLES.
    always_ff @(posedge clk_in1 or negedge reset) begin
        if (!reset) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (!r_locked) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
            if (r_lock_cnt == c_lock_last) begin
                r_locked <= 1'b1;
            end
        end
    end

    clk_div_n #(
        .DIV   (DIV1),
        .PHASE (PHASE1)
    ) u_div1 (
        .clk   (clk_in1),
        .reset (reset),
        .en    (r_locked),
        .clk_o (clk_out1)
    );

    clk_div_n #(
        .DIV   (DIV2),
        .PHASE (PHASE2)
    ) u_div2 (
        .clk   (clk_in1),
        .reset (reset),
        .en    (r_locked),
        .clk_o (clk_out2)
    );

    assign locked = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_clk_wiz_gen.sv
// ============================================================================
// Module   : tb_clk_wiz_gen
// Brief    : Directed self-checking bench for clk_wiz_gen (four configurations).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_wiz_gen;

    logic clk_in1 = 1'b0;
    logic reset   = 1'b0;

    always #5 clk_in1 = ~clk_in1;

    logic d_o1, d_o2, d_lk;   // defaults
    logic p_o1, p_o2, p_lk;   // PHASE1 = 3
    logic x_o1, x_o2, x_lk;   // ratio extremes
    logic a_o1, a_o2, a_lk;   // equal ratios

    clk_wiz_gen u_def (
        .clk_in1 (clk_in1), .reset (reset),
        .clk_out1(d_o1), .clk_out2(d_o2), .locked(d_lk)
    );

    clk_wiz_gen #(.DIV1(5), .DIV2(4), .PHASE1(3), .PHASE2(0), .LOCK_CYCLES(64)) u_ph (
        .clk_in1 (clk_in1), .reset (reset),
        .clk_out1(p_o1), .clk_out2(p_o2), .locked(p_lk)
    );

    clk_wiz_gen #(.DIV1(2), .DIV2(256), .PHASE1(0), .PHASE2(0), .LOCK_CYCLES(1)) u_ext (
        .clk_in1 (clk_in1), .reset (reset),
        .clk_out1(x_o1), .clk_out2(x_o2), .locked(x_lk)
    );

    clk_wiz_gen #(.DIV1(4), .DIV2(4), .PHASE1(0), .PHASE2(0), .LOCK_CYCLES(64)) u_al (
        .clk_in1 (clk_in1), .reset (reset),
        .clk_out1(a_o1), .clk_out2(a_o2), .locked(a_lk)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int e        = 0;   // rising edges since the last reset release

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s (edge %0d): observed %b expected %b", tag, e, obs, exp);
        end
    endtask

    // Expected divider output on edge n after release, from the waveform definition.
    function automatic logic exp_out(input int div, input int phase, input int lockc, input int n);
        int k;
        if (n <= lockc) return 1'b0;
        k = n - lockc - 1;
        return (((phase + k) % div) < (div / 2));
    endfunction

    task automatic check_all();
        check("def_lk", d_lk, e >= 64);
        check("def_o1", d_o1, exp_out(5, 0, 64, e));
        check("def_o2", d_o2, exp_out(4, 0, 64, e));
        check("ph_lk",  p_lk, e >= 64);
        check("ph_o1",  p_o1, exp_out(5, 3, 64, e));
        check("ph_o2",  p_o2, exp_out(4, 0, 64, e));
        check("ext_lk", x_lk, e >= 1);
        check("ext_o1", x_o1, exp_out(2, 0, 1, e));
        check("ext_o2", x_o2, exp_out(256, 0, 1, e));
        check("al_lk",  a_lk, e >= 64);
        check("al_o1",  a_o1, exp_out(4, 0, 64, e));
        check("al_o2",  a_o2, exp_out(4, 0, 64, e));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_def_lk"}, d_lk, 1'b0);
        check({tag, "_def_o1"}, d_o1, 1'b0);
        check({tag, "_def_o2"}, d_o2, 1'b0);
        check({tag, "_ph_lk"},  p_lk, 1'b0);
        check({tag, "_ph_o1"},  p_o1, 1'b0);
        check({tag, "_ph_o2"},  p_o2, 1'b0);
        check({tag, "_ext_lk"}, x_lk, 1'b0);
        check({tag, "_ext_o1"}, x_o1, 1'b0);
        check({tag, "_ext_o2"}, x_o2, 1'b0);
        check({tag, "_al_lk"},  a_lk, 1'b0);
        check({tag, "_al_o1"},  a_o1, 1'b0);
        check({tag, "_al_o2"},  a_o2, 1'b0);
    endtask

    task automatic step();
        @(posedge clk_in1);
        #1;
        e++;
        check_all();
    endtask

    // Hand-written clk_out1 sequence for DIV1=5, PHASE1=3, bit i = edge 65+i.
    logic [8:0] ph_pat = 9'b1_1000_1100;
    logic       found;

    initial begin
        // Power-up: reset held for 10 edges.
        reset = 1'b0;
        repeat (10) begin
            @(posedge clk_in1);
            #1;
            check_zero("por");
        end

        #2 reset = 1'b1;
        e = 0;
        repeat (264) begin
            step();
            if (e >= 65 && e <= 73)
                check("ph_pattern", p_o1, ph_pat[e-65]);
            if (e >= 65 && e <= 74)
                check("def_o1_2h3l", d_o1, ((e - 65) % 5) < 2);
            if (e > 64)
                check("al_equal", a_o1, a_o2);
        end

        // Mid-run reset while clk_out1 is high, applied between edges.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (d_o1) found = 1'b1;
            else      step();
        end
        check("mid_wait_o1_high", found, 1'b1);
        #3 reset = 1'b0;
        #1 check_zero("mid_async");
        repeat (2) begin
            @(posedge clk_in1);
            #1;
            check_zero("mid_hold");
        end

        #3 reset = 1'b1;
        e = 0;
        repeat (70) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
